// File: rtl/decoder_3x8_stream_pkg.sv
// ============================================================================
// Module   : decoder_3x8_stream_pkg
// Brief    : Shared widths, occupancy constants and helpers for the 3x8 decoder.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package decoder_3x8_stream_pkg;

  localparam int CODE_W   = 3;
  localparam int ONEHOT_W = 8;

  localparam logic [1:0] CNT_EMPTY = 2'd0;
  localparam logic [1:0] CNT_FULL  = 2'd2;

  typedef logic [CODE_W-1:0]   code_t;
  typedef logic [ONEHOT_W-1:0] onehot_t;

  // Successor in the walking sequence; wraps 7 -> 0 by width.
  function automatic code_t next_code(input code_t c);
    return c + code_t'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/decoder_3x8.sv
// ============================================================================
// Module   : decoder_3x8
// Brief    : Combinational 3-bit binary to 8-bit one-hot decoder with enable.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module decoder_3x8
  import decoder_3x8_stream_pkg::*;
(
  input  logic    en,
  input  code_t   code,
  output onehot_t onehot
);

  assign onehot = en ? (onehot_t'(1) << code) : '0;

endmodule

`default_nettype wire

// File: rtl/decoder_3x8_stream.sv
// ============================================================================
// Module   : decoder_3x8_stream
// Brief    : Valid/ready 3x8 decoder with 2-entry code FIFO, accept counter
//            and walking-sequence checker.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module decoder_3x8_stream
  import decoder_3x8_stream_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter bit CHECK_SEQ = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             seq_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       d,
  output logic [CNT_W-1:0] code_cnt,
  output logic             seq_err
);

  logic [1:0]       r_occ;
  code_t            r_mem [2];
  logic             r_head;
  logic [CNT_W-1:0] r_code_cnt;
  code_t            r_prev;
  logic             r_have_ref;
  logic             r_seq_err;

  code_t w_code;
  logic  w_accept;
  logic  w_pop;
  logic  w_wr_ptr;

  assign w_code    = {a, b, c};
  assign in_ready  = (r_occ != CNT_FULL);
  assign out_valid = (r_occ != CNT_EMPTY);
  assign w_accept  = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  // With two slots the tail is the head when empty and the other slot otherwise.
  assign w_wr_ptr  = r_head ^ r_occ[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ      <= CNT_EMPTY;
      r_head     <= 1'b0;
      r_mem[0]   <= '0;
      r_mem[1]   <= '0;
      r_code_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_mem[w_wr_ptr] <= w_code;
        r_code_cnt      <= r_code_cnt + CNT_W'(1);
      end
      if (w_pop)
        r_head <= ~r_head;
      case ({w_accept, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // A clear coinciding with an accept makes that code the fresh reference.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev     <= '0;
      r_have_ref <= 1'b0;
      r_seq_err  <= 1'b0;
    end else if (seq_clr) begin
      r_seq_err  <= 1'b0;
      r_have_ref <= w_accept;
      if (w_accept)
        r_prev <= w_code;
    end else if (w_accept) begin
      if (r_have_ref && (w_code != next_code(r_prev)))
        r_seq_err <= 1'b1;
      r_prev     <= w_code;
      r_have_ref <= 1'b1;
    end
  end

  assign seq_err  = CHECK_SEQ && r_seq_err;
  assign code_cnt = r_code_cnt;

  decoder_3x8 u_dec (
    .en     (out_valid),
    .code   (r_mem[r_head]),
    .onehot (d)
  );

endmodule

`default_nettype wire

// File: tb/tb_decoder_3x8_stream.sv
// ============================================================================
// Module   : tb_decoder_3x8_stream
// Brief    : Three decoder instances (default, 4-bit counter, checker off)
//            driven in lockstep and compared to a queue-based reference model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_decoder_3x8_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic a = 1'b0, b = 1'b0, c = 1'b0;
  logic seq_clr = 1'b0;
  logic out_ready = 1'b0;

  logic        m_in_ready, m_out_valid, m_seq_err;
  logic [7:0]  m_d;
  logic [15:0] m_cnt;
  logic        w_in_ready, w_out_valid, w_seq_err;
  logic [7:0]  w_d;
  logic [3:0]  w_cnt;
  logic        n_in_ready, n_out_valid, n_seq_err;
  logic [7:0]  n_d;
  logic [15:0] n_cnt;

  always #5 clk = ~clk;

  decoder_3x8_stream #(.CNT_W(16), .CHECK_SEQ(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(m_in_ready),
    .a(a), .b(b), .c(c), .seq_clr(seq_clr), .out_valid(m_out_valid),
    .out_ready(out_ready), .d(m_d), .code_cnt(m_cnt), .seq_err(m_seq_err));

  decoder_3x8_stream #(.CNT_W(4), .CHECK_SEQ(1'b1)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
    .a(a), .b(b), .c(c), .seq_clr(seq_clr), .out_valid(w_out_valid),
    .out_ready(out_ready), .d(w_d), .code_cnt(w_cnt), .seq_err(w_seq_err));

  decoder_3x8_stream #(.CNT_W(16), .CHECK_SEQ(1'b0)) u_noseq (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(n_in_ready),
    .a(a), .b(b), .c(c), .seq_clr(seq_clr), .out_valid(n_out_valid),
    .out_ready(out_ready), .d(n_d), .code_cnt(n_cnt), .seq_err(n_seq_err));

  // Reference model: queue of pending codes plus plain counters.
  logic [2:0]  q[$];
  int unsigned accepted;
  bit          have_ref;
  int unsigned prev_code;
  bit          err;

  int n_checks = 0;
  int n_pass   = 0;

  logic [2:0] rnd_code;
  logic [2:0] last_code;
  logic       rnd_v, rnd_clr, rnd_rdy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    q.delete();
    accepted  = 0;
    have_ref  = 0;
    prev_code = 0;
    err       = 0;
  endtask

  task automatic model_step(input logic v, input logic [2:0] code, input logic clr, input logic rdy);
    bit acc, pop;
    acc = v && (q.size() < 2);
    pop = (q.size() > 0) && rdy;
    if (pop) void'(q.pop_front());
    if (acc) begin
      q.push_back(code);
      accepted++;
    end
    if (clr) begin
      err      = 0;
      have_ref = acc;
      if (acc) prev_code = code;
    end else if (acc) begin
      if (have_ref && (int'(code) != (prev_code + 1) % 8)) err = 1;
      prev_code = code;
      have_ref  = 1;
    end
  endtask

  task automatic compare_all();
    logic [7:0] exp_d;
    exp_d = (q.size() > 0) ? (8'h01 << q[0]) : 8'h00;
    check("d",           m_d,         exp_d);
    check("out_valid",   m_out_valid, q.size() > 0);
    check("in_ready",    m_in_ready,  q.size() < 2);
    check("code_cnt",    m_cnt,       accepted % 65536);
    check("seq_err",     m_seq_err,   err);
    check("wrap_d",      w_d,         exp_d);
    check("wrap_cnt",    w_cnt,       accepted % 16);
    check("wrap_seq_err",w_seq_err,   err);
    check("noseq_d",     n_d,         exp_d);
    check("noseq_rdy",   n_in_ready,  q.size() < 2);
    check("noseq_err",   n_seq_err,   1'b0);
  endtask

  task automatic cycle(input logic v, input logic [2:0] code, input logic clr, input logic rdy);
    in_valid  = v;
    {a, b, c} = code;
    seq_clr   = clr;
    out_ready = rdy;
    @(posedge clk);
    model_step(v, code, clr, rdy);
    @(negedge clk);
    compare_all();
  endtask

  // Asserts reset away from any clock edge and checks the asynchronous clear.
  task automatic async_reset();
    in_valid = 0; seq_clr = 0; out_ready = 0;
    #2 rst_n = 0;
    #1;
    model_reset();
    check("rst_out_valid", m_out_valid, 1'b0);
    check("rst_d",         m_d,         8'h00);
    check("rst_code_cnt",  m_cnt,       16'd0);
    check("rst_seq_err",   m_seq_err,   1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    compare_all();
    rst_n = 1;
    @(negedge clk);
    compare_all();

    // Walk 0..7 with a free-running sink.
    for (int i = 0; i < 8; i++) cycle(1, 3'(i), 0, 1);
    check("walk_cnt", m_cnt, 16'd8);
    check("walk_err", m_seq_err, 1'b0);
    cycle(0, 0, 0, 1);

    // Backpressure: two codes fill the buffer, the third is refused.
    cycle(1, 3, 0, 0);
    cycle(1, 4, 0, 0);
    check("bp_full", m_in_ready, 1'b0);
    cycle(1, 5, 0, 0);
    check("bp_held_d", m_d, 8'h08);
    cycle(0, 0, 0, 1);
    check("bp_next_d", m_d, 8'h10);
    cycle(0, 0, 0, 1);

    // Sequence break and clear.
    cycle(1, 2, 1, 1);
    cycle(1, 3, 0, 1);
    cycle(1, 5, 0, 1);
    check("seq_set", m_seq_err, 1'b1);
    cycle(1, 6, 0, 1);
    cycle(1, 7, 0, 1);
    check("seq_sticky", m_seq_err, 1'b1);
    cycle(1, 0, 1, 1);
    cycle(1, 1, 0, 1);
    check("seq_clr", m_seq_err, 1'b0);
    cycle(0, 0, 0, 1);

    // Counter wrap on the 4-bit instance: 17 codes from 5.
    async_reset();
    for (int i = 0; i < 17; i++) cycle(1, 3'((5 + i) % 8), 0, 1);
    check("wrap_cnt_final", w_cnt, 4'd1);
    check("wrap_err_final", w_seq_err, 1'b0);
    cycle(0, 0, 0, 1);

    // Reset with the buffer full, then a single code afterwards.
    cycle(1, 1, 0, 0);
    cycle(1, 2, 0, 0);
    async_reset();
    cycle(1, 6, 0, 0);
    check("post_rst_d", m_d, 8'h40);
    cycle(0, 0, 0, 1);

    // Out-of-order codes: only the checker-enabled instances flag.
    cycle(1, 1, 1, 1);
    check("ns_d1", n_d, 8'h02);
    cycle(1, 5, 0, 1);
    check("ns_d2", n_d, 8'h20);
    cycle(1, 2, 0, 1);
    check("ns_d3", n_d, 8'h04);
    cycle(0, 0, 0, 1);
    check("ns_err_main", m_seq_err, 1'b1);

    // Randomised traffic, mostly in-sequence.
    last_code = 0;
    for (int i = 0; i < 400; i++) begin
      rnd_v    = ($urandom_range(0, 9) < 7);
      rnd_code = ($urandom_range(0, 9) < 8) ? 3'(last_code + 3'd1) : 3'($urandom_range(0, 7));
      rnd_clr  = ($urandom_range(0, 19) == 0);
      rnd_rdy  = ($urandom_range(0, 9) < 6);
      if (rnd_v && (q.size() < 2)) last_code = rnd_code;
      cycle(rnd_v, rnd_code, rnd_clr, rnd_rdy);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
